// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive path.
package rgmii_pkg;

  typedef enum logic [1:0] {
    SPD_10  = 2'b00,
    SPD_100 = 2'b01,
    SPD_1G  = 2'b10
  } speed_t;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // 10M and 100M deliver one nibble per clock; the reserved code runs as 1G.
  function automatic logic is_nibble_mode(input logic [1:0] spd);
    return (spd == SPD_10) || (spd == SPD_100);
  endfunction

endpackage

// File: rtl/rgmii_nibble_packer.sv
// Pairs 10/100 nibbles (low nibble first) into bytes. The phase restarts
// whenever dv is low, so every frame starts on a low nibble.
module rgmii_nibble_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nibble_i,
  input  logic       dv_i,
  input  logic       er_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_er_o,
  output logic       odd_nibble_o
);

  logic       phase_q, phase_d;
  logic [3:0] lo_q, lo_d;
  logic       er_lo_q, er_lo_d;

  // Capture the low nibble and its error flag on the first phase.
  always_comb begin
    phase_d = dv_i ? ~phase_q : 1'b0;
    lo_d    = lo_q;
    er_lo_d = er_lo_q;
    if (dv_i && !phase_q) begin
      lo_d    = nibble_i;
      er_lo_d = er_i;
    end
  end

  // Phase and low-nibble registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      lo_q    <= 4'h0;
      er_lo_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
      er_lo_q <= er_lo_d;
    end
  end

  assign byte_o       = {nibble_i, lo_q};
  assign byte_valid_o = dv_i & phase_q;
  assign byte_er_o    = er_lo_q | er_i;
  assign odd_nibble_o = phase_q;

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive controller: lane decode, preamble/SFD strip, payload stream
// with last/error flags and per-frame status pulses.
// Optional build macro RGMII_INBAND_STATUS_EN enables in-band link status
// capture during idle; otherwise the status outputs are tied low.
//
// state     | meaning
// WAIT_IDLE | after reset, wait for dv low before accepting a frame
// IDLE      | between frames; link speed sampled here
// PREAMBLE  | counting 0x55 bytes, waiting for SFD
// PAYLOAD   | streaming payload through the 1-byte hold register
// DROP      | discarding the rest of a bad/oversize frame until dv low
module rgmii_rx_ctrl
  import rgmii_pkg::*;
#(
  parameter int DATA_WIDTH      = 5,
  parameter int MIN_PREAMBLE    = 1,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] q1,
  input  logic [DATA_WIDTH-1:0] q2,
  input  logic [1:0]            link_speed,
  output logic [7:0]            m_rx_tdata,
  output logic                  m_rx_tvalid,
  output logic                  m_rx_tlast,
  output logic                  m_rx_tuser,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic                  link_up,
  output logic [1:0]            link_speed_ib,
  output logic                  full_duplex
);

  localparam logic [7:0]  MIN_PRE_C = 8'(MIN_PREAMBLE);
  localparam logic [10:0] MAX_C     = 11'(MAX_FRAME_BYTES);

  logic       dv, er;
  logic [7:0] pk_byte;
  logic       pk_valid, pk_er, pk_odd;
  logic       nib_mode, b_valid, b_er, odd;
  logic [7:0] b_data, pre_cur;

  rx_state_t   state_q, state_d;
  logic        nib_q, nib_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        err_q, err_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic        ok_q, ok_d, ferr_q, ferr_d;

  assign dv = q1[4];
  assign er = q1[4] ^ q2[4];

  rgmii_nibble_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .nibble_i     (q1[3:0]),
    .dv_i         (dv),
    .er_i         (er),
    .byte_o       (pk_byte),
    .byte_valid_o (pk_valid),
    .byte_er_o    (pk_er),
    .odd_nibble_o (pk_odd)
  );

  // The first byte/nibble of a frame arrives while still in IDLE, so the
  // live speed applies there; afterwards the latched speed is used.
  always_comb begin
    nib_mode = (state_q == IDLE) ? is_nibble_mode(link_speed) : nib_q;
    b_valid  = nib_mode ? pk_valid : dv;
    b_data   = nib_mode ? pk_byte  : {q2[3:0], q1[3:0]};
    b_er     = nib_mode ? pk_er    : er;
    odd      = nib_mode & pk_odd;
    pre_cur  = (state_q == IDLE) ? 8'h00 : pre_cnt_q;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    pre_cnt_d  = pre_cnt_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    err_d      = err_q;
    tdata_d    = 8'h00;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    ok_d       = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      WAIT_IDLE: if (!dv) state_d = IDLE;
      IDLE, PREAMBLE: begin
        pre_cnt_d = pre_cur;
        if (state_q == IDLE) begin
          nib_d      = is_nibble_mode(link_speed);
          cnt_d      = 11'd0;
          hold_vld_d = 1'b0;
          err_d      = 1'b0;
        end
        if (!dv) begin
          state_d = IDLE;
        end else begin
          state_d = PREAMBLE;
          if (b_valid) begin
            if (b_data == PREAMBLE_BYTE) begin
              pre_cnt_d = (pre_cur == 8'hFF) ? pre_cur : pre_cur + 8'd1;
            end else if (b_data == SFD_BYTE && pre_cur >= MIN_PRE_C) begin
              state_d = PAYLOAD;
            end else begin
              state_d = DROP;
            end
          end
        end
      end
      PAYLOAD: begin
        if (!dv) begin
          state_d = IDLE;
          if (hold_vld_q) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
            tlast_d  = 1'b1;
            tuser_d  = err_q | odd;
            ok_d     = ~(err_q | odd);
            ferr_d   = err_q | odd;
          end else begin
            ferr_d = 1'b1;
          end
        end else if (b_valid) begin
          if (b_er) err_d = 1'b1;
          if (cnt_q >= MAX_C) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
            tlast_d  = 1'b1;
            tuser_d  = 1'b1;
            ferr_d   = 1'b1;
            state_d  = DROP;
          end else begin
            tvalid_d   = hold_vld_q;
            tdata_d    = hold_vld_q ? hold_q : 8'h00;
            hold_d     = b_data;
            hold_vld_d = 1'b1;
            cnt_d      = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
          end
        end
      end
      DROP:    if (!dv) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_IDLE;
      nib_q      <= 1'b0;
      pre_cnt_q  <= 8'h00;
      cnt_q      <= 11'd0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      err_q      <= 1'b0;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      ok_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      err_q      <= err_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      ok_q       <= ok_d;
      ferr_q     <= ferr_d;
    end
  end

  assign m_rx_tdata  = tdata_q;
  assign m_rx_tvalid = tvalid_q;
  assign m_rx_tlast  = tlast_q;
  assign m_rx_tuser  = tuser_q;
  assign frame_ok    = ok_q;
  assign frame_err   = ferr_q;

`ifdef RGMII_INBAND_STATUS_EN
  logic       link_up_q;
  logic [1:0] spd_ib_q;
  logic       fd_q;

  // Idle cycles with dv=0, er=0 carry the PHY's link status on rxd.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_up_q <= 1'b0;
      spd_ib_q  <= 2'b00;
      fd_q      <= 1'b0;
    end else if (state_q == IDLE && !dv && !er) begin
      link_up_q <= q1[0];
      spd_ib_q  <= q1[2:1];
      fd_q      <= q1[3];
    end
  end

  assign link_up       = link_up_q;
  assign link_speed_ib = spd_ib_q;
  assign full_duplex   = fd_q;
`else
  assign link_up       = 1'b0;
  assign link_speed_ib = 2'b00;
  assign full_duplex   = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
module tb_rgmii_rx_ctrl;

  localparam int MAXB = 1522;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] q1, q2;
  logic [1:0] link_speed;
  logic [7:0] m_rx_tdata;
  logic       m_rx_tvalid, m_rx_tlast, m_rx_tuser, frame_ok, frame_err;
  logic       link_up, full_duplex;
  logic [1:0] link_speed_ib;

  always #5 clk = ~clk;

  rgmii_rx_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .q1            (q1),
    .q2            (q2),
    .link_speed    (link_speed),
    .m_rx_tdata    (m_rx_tdata),
    .m_rx_tvalid   (m_rx_tvalid),
    .m_rx_tlast    (m_rx_tlast),
    .m_rx_tuser    (m_rx_tuser),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .link_up       (link_up),
    .link_speed_ib (link_speed_ib),
    .full_duplex   (full_duplex)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  typedef struct {
    logic [1:0] spd;
    int         npre;
    logic [7:0] sfd;
    int         npay;
    int         erri;
    bit         odd;
    int         exp_beats;
    int         exp_ok;
    int         exp_err;
  } vec_t;

  beat_t exp_q[$];
  beat_t e_b;
  vec_t  tv[13];
  int    total = 0, bad = 0;
  int    n_valid = 0, n_ok = 0, n_err = 0;
  int    cyc_cnt = 0, last_v_cyc = 0, gap_exp = 1;
  bit    prev_v = 0;

  always @(posedge clk) cyc_cnt++;

  // Scoreboard monitor: pops one expected beat per tvalid.
  always @(negedge clk) begin
    if (m_rx_tvalid === 1'b1) begin
      n_valid++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got d=%02h l=%0b u=%0b", m_rx_tdata, m_rx_tlast, m_rx_tuser);
      end else begin
        e_b = exp_q.pop_front();
        if ({m_rx_tdata, m_rx_tlast, m_rx_tuser} !== {e_b.d, e_b.l, e_b.u}) begin
          bad++;
          $display("FAIL beat got d=%02h l=%0b u=%0b want d=%02h l=%0b u=%0b",
                   m_rx_tdata, m_rx_tlast, m_rx_tuser, e_b.d, e_b.l, e_b.u);
        end
      end
      if (prev_v && !m_rx_tlast) begin
        total++;
        if (cyc_cnt - last_v_cyc != gap_exp) begin
          bad++;
          $display("FAIL beat_gap got=%0d want=%0d", cyc_cnt - last_v_cyc, gap_exp);
        end
      end
      prev_v     = !m_rx_tlast;
      last_v_cyc = cyc_cnt;
    end
    if (frame_ok === 1'b1) n_ok++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic [4:0] a, input logic [4:0] b);
    q1 = a;
    q2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(5'b00000, 5'b00000);
  endtask

  task automatic put_byte(input logic [7:0] v, input bit er, input bit nib);
    if (!nib) begin
      cyc({1'b1, v[3:0]}, {~er, v[7:4]});
    end else begin
      cyc({1'b1, v[3:0]}, {~er, 4'h0});
      cyc({1'b1, v[7:4]}, {~er, 4'h0});
    end
  endtask

  task automatic start_frame(input logic [1:0] spd);
    link_speed = spd;
    gap_exp    = spd[1] ? 1 : 2;
    prev_v     = 0;
    n_valid    = 0;
    n_ok       = 0;
    n_err      = 0;
  endtask

  task automatic end_frame(input string tag, input int beats, input int ok, input int er);
    idle(6);
    check({tag, "_beats"}, n_valid, beats);
    check({tag, "_ok"}, n_ok, ok);
    check({tag, "_err"}, n_err, er);
    check({tag, "_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_frame(input vec_t v, input string tag);
    bit nib;
    bit sfd_ok;
    bit bad_f;
    int n_out;
    nib    = !v.spd[1];
    sfd_ok = (v.sfd == 8'hD5) && (v.npre >= 1);
    n_out  = sfd_ok ? ((v.npay > MAXB) ? MAXB : v.npay) : 0;
    bad_f  = (v.erri >= 0 && v.erri < n_out) || (v.npay > MAXB) || v.odd;
    start_frame(v.spd);
    for (int i = 0; i < v.npre; i++) put_byte(8'h55, 1'b0, nib);
    put_byte(v.sfd, 1'b0, nib);
    for (int i = 0; i < v.npay; i++) begin
      if (i < n_out)
        exp_q.push_back('{d: i[7:0], l: (i == n_out - 1), u: (i == n_out - 1) && bad_f});
      put_byte(i[7:0], (i == v.erri), nib);
    end
    if (v.odd) cyc({1'b1, 4'hA}, {1'b1, 4'h0});
    end_frame(tag, v.exp_beats, v.exp_ok, v.exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // spd, npre, sfd, npay, erri, odd, beats, ok, err
    tv[0]  = '{2'b10, 7, 8'hD5,   64, -1, 0,   64, 1, 0};
    tv[1]  = '{2'b01, 7, 8'hD5,   64, -1, 0,   64, 1, 0};
    tv[2]  = '{2'b10, 7, 8'hD5,   20,  9, 0,   20, 0, 1};
    tv[3]  = '{2'b10, 2, 8'hAA,   10, -1, 0,    0, 0, 0};
    tv[4]  = '{2'b10, 7, 8'hD5,    5, -1, 0,    5, 1, 0};
    tv[5]  = '{2'b10, 0, 8'hD5,    5, -1, 0,    0, 0, 0};
    tv[6]  = '{2'b10, 7, 8'hD5,    0, -1, 0,    0, 0, 1};
    tv[7]  = '{2'b00, 7, 8'hD5,    9, -1, 1,    9, 0, 1};
    tv[8]  = '{2'b10, 1, 8'hD5,    1, -1, 0,    1, 1, 0};
    tv[9]  = '{2'b11, 3, 8'hD5,    3, -1, 0,    3, 1, 0};
    tv[10] = '{2'b10, 7, 8'hD5, 1600, -1, 0, 1522, 0, 1};
    tv[11] = '{2'b10, 7, 8'hD5, 1522, -1, 0, 1522, 1, 0};
    tv[12] = '{2'b01, 7, 8'hD5,   20,  9, 0,   20, 0, 1};

    // Reset with dv high: nothing may start until dv has gone low.
    reset      = 1'b1;
    link_speed = 2'b10;
    cyc(5'b10000, 5'b10000);
    cyc(5'b10000, 5'b10000);
    check("reset_outputs",
          int'({m_rx_tdata, m_rx_tvalid, m_rx_tlast, m_rx_tuser, frame_ok, frame_err,
                link_up, link_speed_ib, full_duplex}), 0);
    reset = 1'b0;
    start_frame(2'b10);
    put_byte(8'hD5, 1'b0, 1'b0);
    put_byte(8'h11, 1'b0, 1'b0);
    put_byte(8'h22, 1'b0, 1'b0);
    end_frame("post_reset_busy", 0, 0, 0);

    for (int k = 0; k < 13; k++) send_frame(tv[k], $sformatf("vec%0d", k));

    // Exact tlast latency; a speed change mid-frame is ignored.
    start_frame(2'b10);
    for (int i = 0; i < 7; i++) put_byte(8'h55, 1'b0, 1'b0);
    put_byte(8'hD5, 1'b0, 1'b0);
    link_speed = 2'b00;
    exp_q.push_back('{d: 8'hA0, l: 1'b0, u: 1'b0});
    exp_q.push_back('{d: 8'hA1, l: 1'b1, u: 1'b0});
    put_byte(8'hA0, 1'b0, 1'b0);
    put_byte(8'hA1, 1'b0, 1'b0);
    q1 = 5'b00000;
    q2 = 5'b00000;
    @(negedge clk);
    check("pre_tlast", int'(m_rx_tlast), 0);
    @(negedge clk);
    check("latency_tlast", int'({m_rx_tvalid, m_rx_tlast, m_rx_tdata}), int'({1'b1, 1'b1, 8'hA1}));
    @(posedge clk);
    #1;
    end_frame("latency", 2, 1, 0);

    // Reset during payload byte 30 of 60 with dv still high.
    start_frame(2'b10);
    for (int i = 0; i < 7; i++) put_byte(8'h55, 1'b0, 1'b0);
    put_byte(8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (i < 29) exp_q.push_back('{d: i[7:0], l: 1'b0, u: 1'b0});
      if (i == 30) reset = 1'b1;
      put_byte(i[7:0], 1'b0, 1'b0);
      if (i == 30) begin
        reset = 1'b0;
        check("reset_mid_outputs",
              int'({m_rx_tdata, m_rx_tvalid, m_rx_tlast, m_rx_tuser, frame_ok, frame_err}), 0);
      end
    end
    end_frame("reset_mid", 29, 0, 0);
    send_frame(tv[4], "after_reset");

    // In-band status during idle.
    cyc(5'b01101, 5'b00000);
    cyc(5'b01101, 5'b00000);
    cyc(5'b01101, 5'b00000);
`ifdef RGMII_INBAND_STATUS_EN
    check("inband_status", int'({link_up, link_speed_ib, full_duplex}), int'(4'b1101));
`else
    check("inband_status", int'({link_up, link_speed_ib, full_duplex}), 0);
`endif
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
